uniq_rand_draw: RTL and testbench

Parametrised unique random-number drawer. A free-running Galois LFSR supplies candidates. Each draw request returns one in-range value that is not already in a DEPTH-entry history, checking every stored entry. Single clock domain with no derived clocks. Sits between the operator control logic (start/draw buttons, already edge-qualified upstream or raw levels) and the RAM/display that stores drawn numbers.

---
 rtl/uniq_rand_draw.sv | 232 +++++++++++++++++++++++
 tb/tb_uniq_rand_draw.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uniq_rand_draw.sv
// ---------------------------------------------------------------------------
// uniq_rand_draw
//
// Unique random-number drawer. A free-running Galois LFSR supplies one
// candidate per clock. Each draw request searches for a candidate that lies
// in [RANGE_MIN, RANGE_MAX] and is not yet stored in the DEPTH-entry history.
// The first such candidate is written to the history and reported on
// draw_num. If no acceptable candidate turns up within MAX_TRIES cycles,
// draw_err pulses instead.
//
// Ports:
//   clk        in   1       clock
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       level; rising edge reseeds LFSR, clears history
//   draw_req   in   1       level; rising edge requests one draw
//   draw_num   out  OUT_W   last accepted value, held until next accept
//   draw_valid out  1       one-cycle pulse when draw_num updates
//   draw_err   out  1       one-cycle pulse on timeout or draw while full
//   busy       out  1       high while searching
//   full       out  1       history holds DEPTH entries
//   count      out  CNT_W   number of valid history entries
//   hist_addr  in   CNT_W   history read index
//   hist_data  out  OUT_W   history[hist_addr], or 0 when hist_addr >= count
//   rand_out   out  LFSR_W  raw LFSR state
// ---------------------------------------------------------------------------
module uniq_rand_draw #(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] TAPS      = 8'h71,
    parameter int                SEED      = 20,
    parameter int                OUT_W     = 7,
    parameter int                RANGE_MIN = 1,
    parameter int                RANGE_MAX = 79,
    parameter int                DEPTH     = 40,
    parameter int                MAX_TRIES = 255,
    parameter int                CNT_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              draw_req,
    output logic [OUT_W-1:0]  draw_num,
    output logic              draw_valid,
    output logic              draw_err,
    output logic              busy,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    input  logic [CNT_W-1:0]  hist_addr,
    output logic [OUT_W-1:0]  hist_data,
    output logic [LFSR_W-1:0] rand_out
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_VAL = (SEED == 0) ? LFSR_W'(1) : LFSR_W'(SEED);
    localparam logic [OUT_W-1:0]  R_MIN    = OUT_W'(RANGE_MIN);
    localparam logic [OUT_W-1:0]  R_MAX    = OUT_W'(RANGE_MAX);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam int                TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t             state;
    state_t             next_state;

    logic               start_d;
    logic               draw_d;
    logic               start_edge;
    logic               draw_edge;

    logic [LFSR_W-1:0]  lfsr;
    logic [OUT_W-1:0]   history [DEPTH];
    logic [TRY_W-1:0]   tries;

    logic [OUT_W-1:0]   cand;
    logic               hit;
    logic               in_range;
    logic               accept;

    logic               take_accept;
    logic               take_timeout;
    logic               full_reject;

    // Rising-edge detection against a one-cycle delayed copy of each input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d <= 1'b0;
            draw_d  <= 1'b0;
        end else begin
            start_d <= start;
            draw_d  <= draw_req;
        end
    end

    assign start_edge = start & ~start_d;
    assign draw_edge  = draw_req & ~draw_d;

    // Free-running Galois LFSR. A zero state is deliberately left stuck until
    // the next start edge reseeds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= '0;
        end else if (start_edge) begin
            lfsr <= SEED_VAL;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], 1'b0} ^ (lfsr[LFSR_W-1] ? TAPS : '0);
        end
    end

    assign rand_out = lfsr;
    assign cand     = lfsr[OUT_W-1:0];

    // Candidate screening: range check plus a parallel compare against every
    // valid history entry.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (history[i] == cand)) begin
                hit = 1'b1;
            end
        end
    end

    assign in_range = (cand >= R_MIN) && (cand <= R_MAX);
    assign accept   = in_range & ~hit;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A start edge wins over everything, including a
    // draw_req edge in the same cycle and an accept in the same cycle.
    always_comb begin
        next_state   = state;
        take_accept  = 1'b0;
        take_timeout = 1'b0;
        full_reject  = 1'b0;
        if (start_edge) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (draw_edge) begin
                        if (full) begin
                            full_reject = 1'b1;
                        end else begin
                            next_state = SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (accept) begin
                        take_accept = 1'b1;
                        next_state  = IDLE;
                    end else if (tries == TRY_LAST) begin
                        take_timeout = 1'b1;
                        next_state   = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Status outputs.
    always_comb begin
        busy = (state == SEARCH);
        full = (count == DEPTH_C);
    end

    // Try counter restarts at zero on every entry into SEARCH because it is
    // held clear in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries <= '0;
        end else if (state == SEARCH) begin
            tries <= tries + TRY_W'(1);
        end else begin
            tries <= '0;
        end
    end

    // History, count and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                history[i] <= '0;
            end
            count      <= '0;
            draw_num   <= '0;
            draw_valid <= 1'b0;
            draw_err   <= 1'b0;
        end else begin
            draw_valid <= take_accept;
            draw_err   <= take_timeout | full_reject;
            if (start_edge) begin
                for (int i = 0; i < DEPTH; i++) begin
                    history[i] <= '0;
                end
                count <= '0;
            end else if (take_accept) begin
                draw_num <= cand;
                if (count < DEPTH_C) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (CNT_W'(i) == count) begin
                            history[i] <= cand;
                        end
                    end
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    // Combinational history read port; entries past count read as zero.
    always_comb begin
        hist_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) == hist_addr) && (hist_addr < count)) begin
                hist_data = history[i];
            end
        end
    end

endmodule

// File: tb/tb_uniq_rand_draw.sv
// ---------------------------------------------------------------------------
// tb_uniq_rand_draw
//
// Directed bench for uniq_rand_draw. Instance dut drives the default
// parameter set; instance dut_b uses a 1..3 range with a 4-entry history and
// a 16-cycle search budget. Expected values follow the LFSR sequence seeded
// with 0x14 under mask 0x71:
//   0x14 0x28 0x50 0xA0 0x31 0x62 0xC4 0xF9 0x83 ... 0xB8 0x01 0x02 ...
// ---------------------------------------------------------------------------
module tb_uniq_rand_draw;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start;
    logic       draw_req;
    logic [5:0] hist_addr;
    logic [6:0] draw_num;
    logic       draw_valid;
    logic       draw_err;
    logic       busy;
    logic       full;
    logic [5:0] count;
    logic [6:0] hist_data;
    logic [7:0] rand_out;

    logic       start_b;
    logic       draw_b;
    logic [2:0] hist_addr_b;
    logic [6:0] draw_num_b;
    logic       draw_valid_b;
    logic       draw_err_b;
    logic       busy_b;
    logic       full_b;
    logic [2:0] count_b;
    logic [6:0] hist_data_b;
    logic [7:0] rand_out_b;

    int vectorCount = 0;
    int errorCount  = 0;

    bit used [128];

    always #5 clk = ~clk;

    uniq_rand_draw dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .draw_req   (draw_req),
        .draw_num   (draw_num),
        .draw_valid (draw_valid),
        .draw_err   (draw_err),
        .busy       (busy),
        .full       (full),
        .count      (count),
        .hist_addr  (hist_addr),
        .hist_data  (hist_data),
        .rand_out   (rand_out)
    );

    uniq_rand_draw #(
        .RANGE_MIN (1),
        .RANGE_MAX (3),
        .DEPTH     (4),
        .MAX_TRIES (16),
        .CNT_W     (3)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .draw_req   (draw_b),
        .draw_num   (draw_num_b),
        .draw_valid (draw_valid_b),
        .draw_err   (draw_err_b),
        .busy       (busy_b),
        .full       (full_b),
        .count      (count_b),
        .hist_addr  (hist_addr_b),
        .hist_data  (hist_data_b),
        .rand_out   (rand_out_b)
    );

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive dut inputs for the current cycle, then step to just after the
    // next rising edge where outputs are observed.
    task automatic applyStimulus(input logic s, input logic d);
        start    = s;
        draw_req = d;
        @(posedge clk);
        #1;
    endtask

    // Hold inputs until dut reports a result, bounded.
    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (draw_valid) begin
                ok = 1'b1;
                break;
            end
            if (draw_err) break;
            applyStimulus(start, draw_req);
        end
    endtask

    // Wait until dut_b's LFSR shows a given state, bounded by a full period.
    task automatic waitRandB(input logic [7:0] target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (rand_out_b == target) begin
                ok = 1'b1;
                break;
            end
            applyStimulus(start, draw_req);
        end
    endtask

    // One dut_b draw launched when the LFSR sits on trigger, so the first
    // candidate is the following state.
    task automatic drawB(input logic [7:0] trigger, input logic [6:0] expected,
                         input string tag);
        bit ok;
        waitRandB(trigger, ok);
        checkOutput({tag, "_sync"}, 32'(ok), 1);
        if (ok) begin
            draw_b = 1'b1;
            applyStimulus(start, draw_req);
            checkOutput({tag, "_busy"}, 32'(busy_b), 1);
            applyStimulus(start, draw_req);
            checkOutput({tag, "_valid"}, 32'(draw_valid_b), 1);
            checkOutput({tag, "_num"}, 32'(draw_num_b), 32'(expected));
        end
        draw_b = 1'b0;
        applyStimulus(start, draw_req);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         ok;
        logic [6:0] v;
        logic [6:0] lastVal;
        logic [7:0] seq [5];

        seq[0] = 8'h14; seq[1] = 8'h28; seq[2] = 8'h50; seq[3] = 8'hA0; seq[4] = 8'h31;
        lastVal = '0;

        rst_n = 1'b0; start = 1'b0; draw_req = 1'b0; hist_addr = '0;
        start_b = 1'b0; draw_b = 1'b0; hist_addr_b = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        $display("[TB] reset values");
        checkOutput("rst_rand",  32'(rand_out), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_full",  32'(full), 0);
        checkOutput("rst_busy",  32'(busy), 0);
        checkOutput("rst_num",   32'(draw_num), 0);
        checkOutput("rst_valid", 32'(draw_valid), 0);
        checkOutput("rst_err",   32'(draw_err), 0);
        checkOutput("rst_rand_b", 32'(rand_out_b), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);

        // LFSR stays stuck at zero until a start edge
        checkOutput("lfsr_stuck", 32'(rand_out), 0);

        // Start edge seeds and LFSR steps
        $display("[TB] LFSR sequence");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("lfsr_%0d", i), 32'(rand_out), 32'(seq[i]));
        end

        // First draw: edge while LFSR=0x14, candidate 0x28 = 40 accepted
        $display("[TB] first draw latency");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("d1_seed", 32'(rand_out), 32'h14);
        applyStimulus(1'b1, 1'b1);
        checkOutput("d1_busy",   32'(busy), 1);
        checkOutput("d1_early",  32'(draw_valid), 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("d1_valid",  32'(draw_valid), 1);
        checkOutput("d1_num",    32'(draw_num), 40);
        checkOutput("d1_count",  32'(count), 1);
        checkOutput("d1_idle",   32'(busy), 0);
        hist_addr = 6'd0;
        #1;
        checkOutput("d1_hist0", 32'(hist_data), 40);
        hist_addr = 6'd1;
        #1;
        checkOutput("d1_hist1", 32'(hist_data), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("d1_pulse", 32'(draw_valid), 0);
        checkOutput("d1_hold",  32'(draw_num), 40);

        // Simultaneous start and draw edges: draw dropped
        $display("[TB] start/draw collision");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("col_count", 32'(count), 0);
        checkOutput("col_busy",  32'(busy), 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("col_valid", 32'(draw_valid), 0);
        checkOutput("col_busy2", 32'(busy), 0);

        // Start during SEARCH aborts; the next draw gives 32 (0x50 rejected, 0xA0 -> 32)
        $display("[TB] start during search");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ab_lfsr", 32'(rand_out), 32'h28);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ab_busy", 32'(busy), 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ab_valid", 32'(draw_valid), 0);
        checkOutput("ab_idle",  32'(busy), 0);
        checkOutput("ab_count", 32'(count), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ab_valid2", 32'(draw_valid), 0);
        applyStimulus(1'b1, 1'b1);
        waitValid(ok);
        checkOutput("ab_next_ok",    32'(ok), 1);
        checkOutput("ab_next_num",   32'(draw_num), 32);
        checkOutput("ab_next_count", 32'(count), 1);

        // Fill the history: 40 distinct in-range values, then a rejected request
        $display("[TB] 40 draws");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("fill_clear", 32'(count), 0);
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, 1'b1);
            waitValid(ok);
            v = draw_num;
            checkOutput($sformatf("fill_ok_%0d", k), 32'(ok), 1);
            checkOutput($sformatf("fill_range_%0d", k), 32'(v >= 7'd1 && v <= 7'd79), 1);
            checkOutput($sformatf("fill_uniq_%0d", k), 32'(used[v]), 0);
            checkOutput($sformatf("fill_count_%0d", k), 32'(count), 32'(k + 1));
            used[v] = 1'b1;
            lastVal = v;
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("fill_full", 32'(full), 1);
        hist_addr = 6'd39;
        #1;
        checkOutput("fill_hist39", 32'(hist_data), 32'(lastVal));
        hist_addr = 6'd40;
        #1;
        checkOutput("fill_hist40", 32'(hist_data), 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("full_err",   32'(draw_err), 1);
        checkOutput("full_busy",  32'(busy), 0);
        checkOutput("full_valid", 32'(draw_valid), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("full_err_pulse", 32'(draw_err), 0);
        checkOutput("full_count",     32'(count), 40);

        // Narrow range instance: 3, 1, 2 then timeout
        $display("[TB] narrow range");
        start_b = 1'b1;
        applyStimulus(start, draw_req);
        checkOutput("b_seed", 32'(rand_out_b), 32'h14);
        drawB(8'hF9, 7'd3, "b_d1");
        drawB(8'hB8, 7'd1, "b_d2");
        drawB(8'h01, 7'd2, "b_d3");
        checkOutput("b_count3", 32'(count_b), 3);
        checkOutput("b_notfull", 32'(full_b), 0);
        for (int a = 0; a < 4; a++) begin
            hist_addr_b = 3'(a);
            #1;
            checkOutput($sformatf("b_hist%0d", a), 32'(hist_data_b),
                        (a == 0) ? 3 : (a == 1) ? 1 : (a == 2) ? 2 : 0);
        end
        draw_b = 1'b1;
        repeat (16) applyStimulus(start, draw_req);
        checkOutput("b_to_busy", 32'(busy_b), 1);
        checkOutput("b_to_early", 32'(draw_err_b), 0);
        applyStimulus(start, draw_req);
        checkOutput("b_to_err",   32'(draw_err_b), 1);
        checkOutput("b_to_idle",  32'(busy_b), 0);
        checkOutput("b_to_count", 32'(count_b), 3);
        checkOutput("b_to_valid", 32'(draw_valid_b), 0);
        draw_b = 1'b0;

        // Asynchronous reset in the middle of a search
        $display("[TB] reset mid-search");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("mr_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_rand",  32'(rand_out), 0);
        checkOutput("mr_count", 32'(count), 0);
        checkOutput("mr_full",  32'(full), 0);
        checkOutput("mr_busy",  32'(busy), 0);
        checkOutput("mr_num",   32'(draw_num), 0);
        checkOutput("mr_valid", 32'(draw_valid), 0);
        checkOutput("mr_count_b", 32'(count_b), 0);
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
